// File: rtl/pwm_pkg.sv
// Shared constants for the PWM block.
package pwm_pkg;
  localparam int unsigned PWM_WIDTH = 16;
endpackage

// File: rtl/pwm_if.sv
// Configuration and output bundle of pwm_core. The master drives the configuration and the slave drives o_pwm.
interface pwm_if
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
);
  logic             duty_sel;
  logic             pwm_core_EN;
  logic             main_counter_EN;
  logic             o_pwm_EN;
  logic [WIDTH-1:0] period_reg;
  logic [WIDTH-1:0] duty_reg;
  logic [WIDTH-1:0] i_DC;
  logic             o_pwm;

  modport master (
    output duty_sel, pwm_core_EN, main_counter_EN, o_pwm_EN,
    output period_reg, duty_reg, i_DC,
    input  o_pwm
  );

  modport slave (
    input  duty_sel, pwm_core_EN, main_counter_EN, o_pwm_EN,
    input  period_reg, duty_reg, i_DC,
    output o_pwm
  );
endinterface

// File: rtl/pwm_counter.sv
// Period counter: it clears when the block is disabled, holds when advance is off, and wraps at period-1.
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             core_en,
  input  logic             cnt_en,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] cnt
);
  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic [WIDTH:0]   cnt_inc;

  // The incremented count is compared one bit wider. With period=0 this pins the count at 0,
  // and the count never has to compare against period-1 wrapping round.
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + (WIDTH+1)'(1);
    cnt_d   = cnt_q;
    if (!core_en) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      if (cnt_inc >= {1'b0, period}) cnt_d = '0;
      else                           cnt_d = cnt_inc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/pwm_core.sv
// PWM core: it selects the duty source, compares it against the period counter and registers the gated output.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
) (
  input  logic clk,
  input  logic rst,
  pwm_if.slave bus
);
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty;
  logic             o_pwm_d, o_pwm_q;

  pwm_counter #(.WIDTH(WIDTH)) u_counter (
    .clk     (clk),
    .rst     (rst),
    .core_en (bus.pwm_core_EN),
    .cnt_en  (bus.main_counter_EN),
    .period  (bus.period_reg),
    .cnt     (cnt)
  );

  always_comb begin
    duty    = bus.duty_sel ? bus.i_DC : bus.duty_reg;
    o_pwm_d = (cnt < duty) && bus.o_pwm_EN && bus.pwm_core_EN;
  end

  always_ff @(posedge clk) begin
    if (rst) o_pwm_q <= 1'b0;
    else     o_pwm_q <= o_pwm_d;
  end

  assign bus.o_pwm = o_pwm_q;
endmodule

// File: tb/tb_pwm_core.sv
// Bench for pwm_core: it runs directed and random stimulus against a cycle-level reference and checks the high time of each frame.
module tb_pwm_core;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;
  int unsigned m_cnt = 0;
  logic        m_pwm = 1'b0;

  pwm_if #(.WIDTH(W)) bus ();

  pwm_core #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // The reference computes the next state from the inputs present before the edge, then checks the state after the edge.
  task automatic tick();
    int unsigned duty, per;
    logic        nxt_pwm;
    int unsigned nxt_cnt;
    duty = bus.duty_sel ? int'(bus.i_DC) : int'(bus.duty_reg);
    per  = int'(bus.period_reg);
    if (rst) begin
      nxt_pwm = 1'b0;
      nxt_cnt = 0;
    end else begin
      nxt_pwm = bus.pwm_core_EN && bus.o_pwm_EN && (m_cnt < duty);
      if (!bus.pwm_core_EN)          nxt_cnt = 0;
      else if (!bus.main_counter_EN) nxt_cnt = m_cnt;
      else                           nxt_cnt = (m_cnt + 1 >= per) ? 0 : m_cnt + 1;
    end
    @(posedge clk);
    #1;
    m_pwm = nxt_pwm;
    m_cnt = nxt_cnt;
    check("o_pwm", {31'd0, bus.o_pwm}, {31'd0, m_pwm});
    check("cnt", {16'd0, dut.u_counter.cnt_q}, m_cnt);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic count_high(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      h += int'(bus.o_pwm);
    end
  endtask

  // After settling, any window that is period cycles long holds min(duty, period) high cycles.
  task automatic frame_check(input string tag, input int per, input int duty);
    int h;
    run(2 * per);
    count_high(per, h);
    check(tag, h, (duty < per) ? duty : per);
  endtask

  initial begin
    int h;
    int unsigned held;
    rst                 = 1'b1;
    bus.duty_sel        = 1'b0;
    bus.pwm_core_EN     = 1'b1;
    bus.main_counter_EN = 1'b1;
    bus.o_pwm_EN        = 1'b1;
    bus.period_reg      = 16'd100;
    bus.duty_reg        = 16'd25;
    bus.i_DC            = 16'd0;
    run(2);
    check("rst_pwm", {31'd0, bus.o_pwm}, 0);
    check("rst_cnt", {16'd0, dut.u_counter.cnt_q}, 0);

    rst = 1'b0;
    tick();
    check("first_high", {31'd0, bus.o_pwm}, 1);
    check("first_cnt", {16'd0, dut.u_counter.cnt_q}, 1);
    frame_check("frame_25_100", 100, 25);

    bus.duty_reg = 16'd75;
    frame_check("frame_75_100", 100, 75);
    bus.period_reg = 16'd200;
    bus.duty_reg   = 16'd100;
    frame_check("frame_100_200", 200, 100);

    bus.period_reg = 16'd100;
    bus.duty_sel   = 1'b1;
    bus.i_DC       = 16'd60;
    frame_check("frame_idc60", 100, 60);
    bus.duty_reg = 16'd0;
    frame_check("frame_idc60_dr0", 100, 60);
    bus.duty_sel = 1'b0;

    bus.period_reg = 16'd20;
    bus.duty_reg   = 16'd15;
    run(27);
    held = m_cnt;
    bus.main_counter_EN = 1'b0;
    run(200);
    check("frozen_cnt", {16'd0, dut.u_counter.cnt_q}, held);
    bus.main_counter_EN = 1'b1;
    frame_check("frame_15_20", 20, 15);

    bus.o_pwm_EN = 1'b0;
    count_high(40, h);
    check("gated_high", h, 0);
    bus.o_pwm_EN = 1'b1;
    frame_check("ungated_15_20", 20, 15);

    bus.pwm_core_EN = 1'b0;
    run(10);
    check("dis_cnt", {16'd0, dut.u_counter.cnt_q}, 0);
    check("dis_pwm", {31'd0, bus.o_pwm}, 0);
    bus.pwm_core_EN = 1'b1;
    bus.duty_reg    = 16'd20;
    frame_check("full_20", 20, 20);
    bus.duty_reg = 16'd0;
    frame_check("zero_20", 20, 0);

    bus.period_reg = 16'd0;
    bus.duty_reg   = 16'd3;
    frame_check("per0_high", 1, 1);
    check("per0_cnt", {16'd0, dut.u_counter.cnt_q}, 0);
    bus.duty_reg = 16'd0;
    frame_check("per0_low", 1, 0);
    bus.period_reg = 16'd1;
    bus.duty_reg   = 16'd1;
    frame_check("per1_high", 1, 1);

    bus.period_reg = 16'd100;
    bus.duty_reg   = 16'd50;
    run(160);
    bus.period_reg = 16'd20;
    tick();
    check("shrink_wrap", {16'd0, dut.u_counter.cnt_q}, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.period_reg = 16'($urandom_range(0, 40));
      if ($urandom_range(0, 19) == 0) bus.duty_reg   = 16'($urandom_range(0, 45));
      if ($urandom_range(0, 19) == 0) bus.i_DC       = 16'($urandom_range(0, 45));
      if ($urandom_range(0, 29) == 0) bus.duty_sel   = ~bus.duty_sel;
      bus.pwm_core_EN     = ($urandom_range(0, 15) != 0);
      bus.main_counter_EN = ($urandom_range(0, 5) != 0);
      bus.o_pwm_EN        = ($urandom_range(0, 7) != 0);
      rst                 = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_core.md
PWM_CORE -- requirements
Module: pwm_core

Interface
REQ-001 Parameter: WIDTH, 16, bit width of counter, period and duty values.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 duty_sel  input  1  duty source select: 0 = duty_reg, 1 = i_DC.
REQ-005 pwm_core_EN  input  1  block enable; 0 = counter cleared and output low.
REQ-006 main_counter_EN  input  1  counter advance enable; 0 = counter holds its value.
REQ-007 o_pwm_EN  input  1  output gate; 0 = o_pwm forced low, counter unaffected.
REQ-008 period_reg  input  WIDTH  PWM period in clk cycles.
REQ-009 duty_reg  input  WIDTH  register duty value in clk cycles of high time.
REQ-010 i_DC  input  WIDTH  external duty value in clk cycles of high time.
REQ-011 o_pwm  output  1  registered PWM output.

Function
REQ-012 The block SHALL hold an internal WIDTH-bit counter, cnt, unsigned throughout.
REQ-013 When pwm_core_EN=1 and main_counter_EN=1, cnt SHALL increment each cycle and wrap to 0 on the cycle after cnt >= period_reg-1.
REQ-014 When pwm_core_EN=1 and main_counter_EN=0, cnt SHALL hold its value.
REQ-015 When pwm_core_EN=0, cnt SHALL be loaded with 0 on every clock edge, regardless of main_counter_EN.
REQ-016 Effective duty SHALL be duty_reg when duty_sel=0 and i_DC when duty_sel=1, selected combinationally with no shadowing.
REQ-017 o_pwm SHALL be registered as (cnt < duty) AND o_pwm_EN AND pwm_core_EN, using the cnt value of that cycle (one cycle latency from cnt to o_pwm).
REQ-018 period_reg, duty_reg and i_DC SHALL be used live; a mid-period change takes effect on the next edge.
REQ-019 When a period is shortened below the current cnt, the wrap rule of REQ-013 SHALL return cnt to 0 on the next enabled cycle.
REQ-020 duty=0 SHALL give a constant low o_pwm.
REQ-021 duty >= period_reg SHALL give a constant high o_pwm (100%).
REQ-022 period_reg=0 SHALL hold cnt at 0, and o_pwm SHALL then follow REQ-017, so it is high only when duty > 0.
REQ-023 period_reg=1 SHALL hold cnt at 0, giving 100% high when duty >= 1.
REQ-024 With a steady configuration, the high time SHALL be min(duty, period_reg) cycles per period_reg-cycle frame.

Reset
REQ-025 On a clock edge with rst=1, cnt SHALL become 0 and o_pwm SHALL become 0; rst has priority over all enables.
REQ-026 After rst falls with all enables=1, the first edge SHALL advance cnt from 0.
REQ-027 o_pwm SHALL go high one cycle after reset release when duty > 0.

Structure
REQ-028 Package pwm_pkg SHALL hold the WIDTH default constant; no typedefs are required.
REQ-029 One sub-module, pwm_counter, SHALL implement the counter (enable, hold, clear, wrap); compare and gating logic SHALL live in pwm_core.

Verification
REQ-030 Reset, period_reg=100, duty_reg=25, duty_sel=0, all enables=1 -> o_pwm high 25 cycles, low 75 cycles, repeating every 100 cycles.
REQ-031 duty_reg changed to 75 -> o_pwm high 75 and low 25 per frame; period_reg=200 with duty_reg=100 -> 100/100.
REQ-032 duty_sel=1, i_DC=60, period_reg=100 (duty_reg ignored) -> high 60, low 40; duty_reg=0 with i_DC=60 is unchanged.
REQ-033 period_reg=20, duty_reg=15, main_counter_EN=0 for 200 cycles -> cnt frozen and o_pwm constant at its last value; re-enable -> 15/5 pattern resumes from the held cnt.
REQ-034 o_pwm_EN=0 -> o_pwm=0 while cnt keeps running; re-enable -> output realigned to cnt with no phase reset.
REQ-035 pwm_core_EN=0 -> o_pwm=0 and cnt=0; duty=period_reg=20 -> constant high; duty=0 -> constant low.
